// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter (start, 8 data LSB-first, stop) with one-deep holding register.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, hold;
  logic hold_full, load, last, tx_n, accept;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
  assign par_n = load ? ^hold : par;
  always_ff @(posedge clk or negedge reset)
    if (!reset) par <= 1'b0;
    else par <= par_n;
`endif
  assign last = cnt == LAST;
  assign accept = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign tx_busy = state != IDLE;
  assign tx_done = state == STOP && last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      hold_full <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      hold_full <= accept ? 1'b1 : load ? 1'b0 : hold_full;
      tx <= tx_n;
    end
  // Holding register is written only while empty, so a queued byte is never overwritten.
  always_ff @(posedge clk)
    if (accept) hold <= tx_data;
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (hold_full) begin
          load = 1'b1;
          state_n = START;
        end
      end
      START: if (last) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        idx_n = idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) state_n = STOP;
`endif
      STOP: if (last) begin
        load = hold_full;
        state_n = hold_full ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (load) shift_n = hold;
    // tx is precomputed from the next state so the pin comes straight off a flop.
`ifdef UART_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized and directed checks of uart_tx_frame against a frame-level model.
module tb_uart_tx_frame;
  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_81 = 11'b10100000010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
`else
  localparam int FB = 10;
  localparam logic [10:0] EXP_A5 = 11'b01101001010;
  localparam logic [10:0] EXP_81 = 11'b01100000010;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
`endif
  localparam int F = FB * N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] tx_data = 8'h5A;
  logic tx_valid = 1'b1;
  logic tx_ready, tx, tx_busy, tx_done;
  int total = 0;
  int bad = 0;

  uart_tx_frame #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Frame-level model: an active frame is a bit vector plus a cycle offset into it.
  logic m_act = 1'b0;
  logic m_hf = 1'b0;
  logic [7:0] m_hb = 8'h00;
  logic [10:0] m_fr = '0;
  int m_t = 0;

  initial forever begin
    logic acc;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_act = 1'b0;
      m_hf = 1'b0;
      m_t = 0;
    end else begin
      acc = tx_valid && !m_hf;
      if (m_act) begin
        m_t++;
        if (m_t == F) begin
          if (m_hf) begin
            m_fr = frame(m_hb);
            m_hf = 1'b0;
            m_t = 0;
          end else m_act = 1'b0;
        end
      end else if (m_hf) begin
        m_act = 1'b1;
        m_fr = frame(m_hb);
        m_hf = 1'b0;
        m_t = 0;
      end
      if (acc) begin
        m_hf = 1'b1;
        m_hb = tx_data;
      end
    end
  end

  initial forever begin
    logic [3:0] got, want;
    @(negedge clk);
    got = {tx, tx_ready, tx_busy, tx_done};
    want = {m_act ? m_fr[m_t / N] : 1'b1, !m_hf, m_act, m_act && m_t == F - 1};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model t=%0t {tx,ready,busy,done} got=%b want=%b", $time, got, want);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = !tx_busy && tx_ready;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [10:0] exp, input string nm);
    logic s [0:F-1];
    int nd, dpos, nb, got, want;
    wait_idle();
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    nd = 0;
    dpos = -1;
    nb = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      s[i] = tx;
      if (tx_done) begin
        nd++;
        dpos = i + 1;
      end
      if (tx_busy) nb++;
    end
    @(negedge clk);
    chk({nm, "_busy_after"}, int'(tx_busy), 0);
    for (int b = 0; b < FB; b++) begin
      got = 0;
      for (int j = 0; j < N; j++) got = got * 2 + int'(s[b * N + j]);
      want = exp[b] ? (1 << N) - 1 : 0;
      chk($sformatf("%s_bit%0d", nm, b), got, want);
    end
    chk({nm, "_done_cnt"}, nd, 1);
    chk({nm, "_done_pos"}, dpos, F);
    chk({nm, "_busy_cnt"}, nb, F);
  endtask

  task automatic back_to_back();
    int cyc, nd, first_rdy, acc;
    wait_idle();
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    chk("b2b_busy_start", int'(tx_busy), 1);
    @(negedge clk);
    chk("b2b_ready_drop", int'(tx_ready), 0);
    tx_data = 8'h11;
    cyc = 2;
    nd = 0;
    first_rdy = 0;
    acc = 0;
    while (tx_busy && cyc < 4 * F) begin
      if (tx_done) nd++;
      if (tx_valid && tx_ready) begin
        acc++;
        if (first_rdy == 0) first_rdy = cyc;
      end
      @(negedge clk);
      if (acc > 0) tx_valid = 1'b0;
      cyc++;
    end
    chk("b2b_busy_span", cyc, 3 * F + 1);
    chk("b2b_done_cnt", nd, 3);
    chk("b2b_accepts_11", acc, 1);
    chk("b2b_first_ready", first_rdy, F + 1);
  endtask

  task automatic reset_mid_frame();
    wait_idle();
    tx_valid = 1'b1;
    tx_data = 8'h55;
    @(negedge clk);
    tx_data = 8'h99;
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_tx", int'(tx), 0);
    chk("pre_rst_ready", int'(tx_ready), 0);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_ready", int'(tx_ready), 1);
    chk("rst_mid_busy", int'(tx_busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_queue_dropped", int'(tx_busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    @(negedge clk);
    tx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(tx_busy), 0);
    send_frame(8'hA5, EXP_A5, "a5");
    back_to_back();
    reset_mid_frame();
    send_frame(8'h81, EXP_81, "r81");
    send_frame(8'h07, EXP_07, "f07");
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tx_valid = $urandom_range(0, 3) == 0;
      tx_data = 8'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    tx_valid = 1'b0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
